// File: rtl/calc_seq_if.sv
// Request, result and ALU-side signals of the calculator sequencer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface calc_seq_if #(
   parameter int DW = 11,
   parameter int AW = 16
);
   logic          IN_VALID;
   logic          IN_READY;
   logic [DW-1:0] IN_A;
   logic [DW-1:0] IN_B;
   logic [1:0]    IN_OP;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [DW-1:0] RESULT;
   logic          OVF;
   logic          ERR;
   logic          ZERO;
   logic          NEG;
   logic [AW-1:0] ALU_A;
   logic [AW-1:0] ALU_B;
   logic [2:0]    ALU_CTRL;
   logic [AW-1:0] ALU_RESULT;

   modport slave (
      input  IN_VALID, IN_A, IN_B, IN_OP, OUT_READY, ALU_RESULT,
      output IN_READY, OUT_VALID, RESULT, OVF, ERR, ZERO, NEG,
             ALU_A, ALU_B, ALU_CTRL
   );

   modport master (
      output IN_VALID, IN_A, IN_B, IN_OP, OUT_READY, ALU_RESULT,
      input  IN_READY, OUT_VALID, RESULT, OVF, ERR, ZERO, NEG,
             ALU_A, ALU_B, ALU_CTRL
   );
endinterface

// File: rtl/calc_seq.sv
// Calculator sequencer: add, subtract and shift-add multiply on a shared
// external add/sub ALU, with saturation to the signed DW-bit result range.
module calc_seq #(
   parameter int DW = 11,
   parameter int AW = 16
) (
   input logic       CLK,
   input logic       RST_N,
   calc_seq_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ALU, MSTEP, MNEG, DONE} state_t;

   localparam logic signed [AW-1:0] SAT_HI  = AW'((1 << (DW-1)) - 1);
   localparam logic signed [AW-1:0] SAT_LO  = ~SAT_HI;
   localparam logic        [AW-1:0] MUL_LIM = AW'(1 << (DW-1));

   state_t        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] mcand_q, mcand_d;
   logic [AW-1:0] mplier_q, mplier_d;
   logic          sign_q, sign_d;
   logic          op_sub_q, op_sub_d;
   logic [DW-1:0] result_q, result_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;

   logic [AW-1:0] alu_a, alu_b;
   logic [2:0]    alu_ctrl;
   logic [AW-1:0] acc_new, mcand_nx, mplier_nx, b_mag;

   function automatic logic [AW-1:0] sext(input logic [DW-1:0] x);
      return {{(AW-DW){x[DW-1]}}, x};
   endfunction

   function automatic logic [AW-1:0] mag(input logic [DW-1:0] x);
      logic [AW-1:0] v;
      v = sext(x);
      return x[DW-1] ? (~v + 1'b1) : v;
   endfunction

   // Returns {ovf, result} after clamping a signed AW-bit value into DW bits.
   function automatic logic [DW:0] sat_range(input logic [AW-1:0] v);
      if ($signed(v) > SAT_HI) begin
         return {1'b1, SAT_HI[DW-1:0]};
      end else if ($signed(v) < SAT_LO) begin
         return {1'b1, SAT_LO[DW-1:0]};
      end else begin
         return {1'b0, v[DW-1:0]};
      end
   endfunction

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      sign_d    = sign_q;
      op_sub_d  = op_sub_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      err_d     = err_q;
      alu_a     = '0;
      alu_b     = '0;
      alu_ctrl  = 3'b000;
      acc_new   = acc_q;
      mcand_nx  = mcand_q << 1;
      mplier_nx = mplier_q >> 1;
      b_mag     = mag(bus.IN_B);

      case (state_q)
         IDLE: begin
            if (bus.IN_VALID) begin
               ovf_d = 1'b0;
               err_d = 1'b0;
               case (bus.IN_OP)
                  // add/sub reuse acc/mcand as the sign-extended operand registers
                  2'b00, 2'b01: begin
                     acc_d    = sext(bus.IN_A);
                     mcand_d  = sext(bus.IN_B);
                     op_sub_d = bus.IN_OP[0];
                     state_d  = ALU;
                  end
                  2'b10: begin
                     acc_d    = '0;
                     mcand_d  = mag(bus.IN_A);
                     mplier_d = b_mag;
                     sign_d   = bus.IN_A[DW-1] ^ bus.IN_B[DW-1];
                     if (b_mag == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                     end else begin
                        state_d  = MSTEP;
                     end
                  end
                  default: begin
                     result_d = '0;
                     err_d    = 1'b1;
                     state_d  = DONE;
                  end
               endcase
            end
         end

         ALU: begin
            alu_a             = acc_q;
            alu_b             = mcand_q;
            alu_ctrl          = {2'b00, op_sub_q};
            {ovf_d, result_d} = sat_range(bus.ALU_RESULT);
            state_d           = DONE;
         end

         MSTEP: begin
            if (mplier_q[0]) begin
               alu_a   = acc_q;
               alu_b   = mcand_q;
               acc_new = bus.ALU_RESULT;
            end
            acc_d    = acc_new;
            mcand_d  = mcand_nx;
            mplier_d = mplier_nx;
            // Aborting once a partial exceeds 2^(DW-1) keeps acc+mcand within AW bits.
            if ((acc_new > MUL_LIM) || ((mplier_nx != '0) && (mcand_nx > MUL_LIM))) begin
               ovf_d    = 1'b1;
               result_d = sign_q ? SAT_LO[DW-1:0] : SAT_HI[DW-1:0];
               state_d  = DONE;
            end else if (mplier_nx == '0) begin
               if (sign_q) begin
                  state_d = MNEG;
               end else begin
                  {ovf_d, result_d} = sat_range(acc_new);
                  state_d           = DONE;
               end
            end
         end

         MNEG: begin
            alu_a             = '0;
            alu_b             = acc_q;
            alu_ctrl          = 3'b001;
            acc_d             = bus.ALU_RESULT;
            {ovf_d, result_d} = sat_range(bus.ALU_RESULT);
            state_d           = DONE;
         end

         DONE: begin
            if (bus.OUT_READY) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         op_sub_q <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         op_sub_q <= op_sub_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
      end
   end

   assign bus.IN_READY  = (state_q == IDLE);
   assign bus.OUT_VALID = (state_q == DONE);
   assign bus.RESULT    = result_q;
   assign bus.OVF       = ovf_q;
   assign bus.ERR       = err_q;
   assign bus.ZERO      = (result_q == '0);
   assign bus.NEG       = result_q[DW-1];
   assign bus.ALU_A     = alu_a;
   assign bus.ALU_B     = alu_b;
   assign bus.ALU_CTRL  = alu_ctrl;

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq: a behavioural ALU plus an arithmetic reference
// model whose expected results are queued at each accepted request.
module tb_calc_seq;
   localparam int DW = 11;
   localparam int AW = 16;

   typedef struct {
      int expResult;
      int expOvf;
      int expErr;
      int expLat;
      int startCycle;
   } sbEntry_t;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   bit   prevValid = 1'b0;
   sbEntry_t sb[$];

   calc_seq_if #(.DW(DW), .AW(AW)) bus ();

   calc_seq #(.DW(DW), .AW(AW)) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle <= cycle + 1;

   assign bus.ALU_RESULT = (bus.ALU_CTRL == 3'b001) ? (bus.ALU_A - bus.ALU_B)
                                                    : (bus.ALU_A + bus.ALU_B);

   task checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task applyStimulus(input int a, input int b, input logic [1:0] op);
      sbEntry_t e;
      int full, m, bits, waitCount;
      case (op)
         2'b00:   full = a + b;
         2'b01:   full = a - b;
         2'b10:   full = a * b;
         default: full = 0;
      endcase
      e.expErr    = (op == 2'b11) ? 1 : 0;
      e.expOvf    = 0;
      e.expResult = full;
      if (full > 1023) begin
         e.expResult = 1023;
         e.expOvf    = 1;
      end else if (full < -1024) begin
         e.expResult = -1024;
         e.expOvf    = 1;
      end
      if (op == 2'b11) begin
         e.expLat = 1;
      end else if (op != 2'b10) begin
         e.expLat = 2;
      end else if (b == 0) begin
         e.expLat = 1;
      end else if (e.expOvf == 1) begin
         e.expLat = -1;
      end else begin
         m = (b < 0) ? -b : b;
         bits = 0;
         while (m != 0) begin
            bits++;
            m = m >> 1;
         end
         e.expLat = bits + (((a < 0) != (b < 0)) ? 1 : 0) + 1;
      end

      @(negedge CLK);
      waitCount = 0;
      while (!bus.IN_READY && waitCount < 60) begin
         @(negedge CLK);
         waitCount++;
      end
      if (!bus.IN_READY) begin
         checkOutput("inReadyTimeout", 0, 1);
         return;
      end
      bus.IN_A     = a[DW-1:0];
      bus.IN_B     = b[DW-1:0];
      bus.IN_OP    = op;
      bus.IN_VALID = 1'b1;
      e.startCycle = cycle;
      sb.push_back(e);
      @(posedge CLK);
      #1 bus.IN_VALID = 1'b0;
   endtask

   task waitDrain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("drain", sb.size(), 0);
   endtask

   // Every valid cycle is checked against the head of the queue; it is retired on handshake.
   always @(negedge CLK) begin
      if (!RST_N) begin
         prevValid <= 1'b0;
      end else if (bus.OUT_VALID) begin
         checkOutput("sbSize", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            if (!prevValid && sb[0].expLat >= 0)
               checkOutput("latency", cycle - sb[0].startCycle, sb[0].expLat);
            checkOutput("result", $signed(bus.RESULT), sb[0].expResult);
            checkOutput("inReadyLow", bus.IN_READY, 0);
            if (bus.OUT_READY) begin
               checkOutput("ovf", bus.OVF, sb[0].expOvf);
               checkOutput("err", bus.ERR, sb[0].expErr);
               checkOutput("zero", bus.ZERO, (sb[0].expResult == 0) ? 1 : 0);
               checkOutput("neg", bus.NEG, (sb[0].expResult < 0) ? 1 : 0);
               checkOutput("aluIdle", int'({bus.ALU_A, bus.ALU_B, bus.ALU_CTRL} != '0), 0);
               void'(sb.pop_front());
            end
         end
         prevValid <= !bus.OUT_READY;
      end else begin
         prevValid <= 1'b0;
      end
   end

   initial begin
      int n;
      int ra, rb;
      logic [1:0] rop;
      bus.IN_VALID  = 1'b0;
      bus.IN_A      = '0;
      bus.IN_B      = '0;
      bus.IN_OP     = 2'b00;
      bus.OUT_READY = 1'b1;
      RST_N         = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("rstInReady", bus.IN_READY, 1);
      checkOutput("rstOutValid", bus.OUT_VALID, 0);
      checkOutput("rstResult", $signed(bus.RESULT), 0);
      checkOutput("rstZero", bus.ZERO, 1);
      checkOutput("rstAluCtrl", bus.ALU_CTRL, 0);

      applyStimulus(300, 400, 2'b00);
      applyStimulus(-1024, 1, 2'b01);
      applyStimulus(5, 5, 2'b01);
      applyStimulus(32, -32, 2'b10);
      applyStimulus(33, 33, 2'b10);
      applyStimulus(-25, 40, 2'b10);
      applyStimulus(0, -5, 2'b10);
      applyStimulus(7, 0, 2'b10);
      applyStimulus(32, 32, 2'b10);
      applyStimulus(-1024, 1, 2'b10);
      applyStimulus(-1024, -1024, 2'b00);
      applyStimulus(1023, 1023, 2'b00);
      applyStimulus(5, 5, 2'b11);
      waitDrain();

      $display("[TB] backpressure");
      bus.OUT_READY = 1'b0;
      applyStimulus(100, -200, 2'b00);
      n = 0;
      while (!bus.OUT_VALID && n < 20) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("bpValid", bus.OUT_VALID, 1);
      bus.IN_A     = 11'd1;
      bus.IN_B     = 11'd1;
      bus.IN_OP    = 2'b00;
      bus.IN_VALID = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         checkOutput("bpHeld", bus.OUT_VALID, 1);
      end
      bus.IN_VALID = 1'b0;
      @(posedge CLK);
      #1 bus.OUT_READY = 1'b1;
      waitDrain();

      $display("[TB] reset during multiply");
      applyStimulus(7, 300, 2'b10);
      repeat (2) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      sb.delete();
      checkOutput("midRstValid", bus.OUT_VALID, 0);
      checkOutput("midRstInReady", bus.IN_READY, 1);
      checkOutput("midRstResult", $signed(bus.RESULT), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (15) @(negedge CLK);
      checkOutput("midRstQuiet", bus.OUT_VALID, 0);

      $display("[TB] random operations");
      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         if (rop == 2'b10 && (i % 2 == 0)) begin
            ra = int'($urandom_range(0, 80)) - 40;
            rb = int'($urandom_range(0, 80)) - 40;
         end else begin
            ra = int'($urandom_range(0, 2047)) - 1024;
            rb = int'($urandom_range(0, 2047)) - 1024;
         end
         applyStimulus(ra, rb, rop);
      end
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
